// File: rtl/player_shot_ctrl.sv
// player_shot_ctrl: single player missile - launches from the cannon centre on a fire edge,
// climbs SHOT_SPEED pixels per frame, retires on hit/top edge/player death, then cools down.
module player_shot_ctrl #(
   parameter int PLAYER_W        = 32,
   parameter int SHOT_W          = 4,
   parameter int SHOT_H          = 16,
   parameter int SHOT_SPEED      = 8,
   parameter int TOP_LIMIT       = 0,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        fireKey,
   input  logic [10:0] playerX,
   input  logic [10:0] playerY,
   input  logic        shotHit,
   input  logic        plrHit,
   output logic [10:0] shotTopLeftX,
   output logic [10:0] shotTopLeftY,
   output logic        shotActive,
   output logic        shotFired
);
   localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CW-1:0] CNT_INIT   = CW'(COOLDOWN_FRAMES);
   localparam logic [10:0]   X_OFS      = 11'(PLAYER_W / 2 - SHOT_W / 2);
   localparam logic [10:0]   TOP        = 11'(TOP_LIMIT);
   localparam logic [10:0]   LAUNCH_MIN = 11'(TOP_LIMIT + SHOT_H);
   localparam logic [10:0]   MOVE_MIN   = 11'(TOP_LIMIT + SHOT_SPEED);

   typedef enum logic [1:0] {READY, FLYING, COOLDOWN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [10:0]   x_q, x_d, y_q, y_d;
   logic          pend_q, pend_d, fire_key_q, active_q, fired_q, fired_d, fire_edge;

   assign fire_edge = fireKey & ~fire_key_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      pend_d  = pend_q;
      fired_d = 1'b0;
      if (plrHit) begin
         state_d = COOLDOWN;
         cnt_d   = CNT_INIT;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            READY: begin
               if (startOfFrame && (pend_q || fire_edge)) begin
                  state_d = FLYING;
                  pend_d  = 1'b0;
                  fired_d = 1'b1;
                  x_d     = playerX + X_OFS;
                  y_d     = (playerY < LAUNCH_MIN) ? TOP : playerY - 11'(SHOT_H);
               end else if (fire_edge) begin
                  pend_d = 1'b1;
               end
            end
            FLYING: begin
               // underflow is tested before subtracting so Y never wraps
               if (shotHit || (startOfFrame && y_q < MOVE_MIN)) begin
                  state_d = COOLDOWN;
                  cnt_d   = CNT_INIT;
               end else if (startOfFrame) begin
                  y_d = y_q - 11'(SHOT_SPEED);
               end
            end
            COOLDOWN: begin
               if (COOLDOWN_FRAMES == 0) begin
                  state_d = READY;
               end else if (startOfFrame) begin
                  cnt_d   = cnt_q - CW'(1);
                  state_d = (cnt_q == CW'(1)) ? READY : COOLDOWN;
               end
            end
            default: state_d = READY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= READY;
         cnt_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         pend_q     <= 1'b0;
         fire_key_q <= 1'b0;
         active_q   <= 1'b0;
         fired_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         pend_q     <= pend_d;
         fire_key_q <= fireKey;
         active_q   <= (state_d == FLYING);
         fired_q    <= fired_d;
      end
   end

   assign shotTopLeftX = x_q;
   assign shotTopLeftY = y_q;
   assign shotActive   = active_q;
   assign shotFired    = fired_q;
endmodule

// File: doc/player_shot_ctrl.md
# player_shot_ctrl

Player missile controller, directly downstream of the player movement block. It consumes the player's top-left position and the fire key, launches a single missile from the centre of the cannon, and moves it up the screen once per frame. It retires the missile on a hit or when it leaves the top edge, then enforces a cooldown before the next shot. Its outputs feed the missile drawing object, the collision logic and the sound/score logic.

## Interface
Parameters:
- PLAYER_W, 32: player sprite width in pixels.
- SHOT_W, 4: missile width in pixels.
- SHOT_H, 16: missile height in pixels.
- SHOT_SPEED, 8: upward movement in pixels per frame.
- TOP_LIMIT, 0: smallest legal missile Y.
- COOLDOWN_FRAMES, 8: frames after retirement before re-arming.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset; asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame (30 Hz).
- fireKey  in  1  fire key level, already synchronous to clk.
- playerX  in  11  player topLeftX, unsigned.
- playerY  in  11  player topLeftY, unsigned.
- shotHit  in  1  missile collided (alien, shield, saucer); level.
- plrHit  in  1  player destroyed; synchronous clear.
- shotTopLeftX  out  11  missile top-left X.
- shotTopLeftY  out  11  missile top-left Y.
- shotActive  out  1  missile in flight; gates drawing and collision.
- shotFired  out  1  one-cycle pulse on launch.

## Operation
- States:
  - READY (reset state).
  - FLYING.
  - COOLDOWN, with a frame counter (width ≥ clog2(COOLDOWN_FRAMES+1)).
- Fire edge detection:
  - fireEdge = fireKey & ~fireKey_d, where fireKey_d is registered (reset value 0).
  - An edge is latched into firePending only in READY.
  - firePending clears on launch and on every transition out of READY.
  - Edges seen in FLYING or COOLDOWN are discarded.
  - Holding the key produces exactly one shot.
- READY:
  - Launch condition: startOfFrame & (firePending | fireEdge).
  - On launch:
    - shotTopLeftX = playerX + PLAYER_W/2 − SHOT_W/2.
    - shotTopLeftY = playerY − SHOT_H, clamped to TOP_LIMIT if playerY < TOP_LIMIT + SHOT_H.
    - shotFired pulses.
    - Go to FLYING.
- FLYING, on startOfFrame:
  - If shotTopLeftY < TOP_LIMIT + SHOT_SPEED: go to COOLDOWN (missile left the screen). Y is not decremented.
  - Otherwise Y −= SHOT_SPEED.
  - X is frozen for the whole flight and does not track the player.
- FLYING, on shotHit (any cycle): go to COOLDOWN and hold Y.
- COOLDOWN:
  - On entry, the counter loads COOLDOWN_FRAMES.
  - The counter decrements on each startOfFrame.
  - On the startOfFrame that finds the counter at 1, go to READY.
  - COOLDOWN_FRAMES = 0 means go directly to READY on the next cycle.
- plrHit (any state): go to COOLDOWN, reload the counter, clear firePending.
- Priority within a cycle: resetN > plrHit > shotHit > startOfFrame move/launch.
- shotActive = (state == FLYING), registered.
- Arithmetic:
  - All 11-bit unsigned.
  - The underflow test is done before subtracting, so Y never wraps.
  - Launch X is not clamped; the movement block keeps playerX legal.
- shotTopLeftX/Y hold their last value when inactive. Consumers must gate on shotActive.

## Timing
- Reset values: state READY, counter 0, firePending 0, shotTopLeftX 0, shotTopLeftY 0, shotActive 0, shotFired 0.
- Latency of a startOfFrame effect: all outputs update on the clock edge that samples startOfFrame and are visible the following cycle.
- shotFired is high for exactly one cycle, coincident with the first cycle of shotActive = 1.
- shotHit: shotActive drops the cycle after shotHit is sampled.
- shotHit and startOfFrame in the same cycle: the hit wins, there is no move, and Y holds its pre-frame value.
- fireEdge coinciding with startOfFrame in READY launches in that frame.
- Re-arm to launch: the minimum is the same startOfFrame that enters READY, if firePending was set. It cannot be, because edges are discarded outside READY, so the earliest launch is the next frame.

## Test plan
- Reset: assert resetN = 0 mid-flight → all outputs 0 and state READY immediately (asynchronously). After release, no shot occurs without a new fire edge.
- Launch: playerX = 320, playerY = 450, pulse fireKey, then startOfFrame → shotActive = 1, shotTopLeftX = 334, shotTopLeftY = 434, shotFired high for 1 cycle.
- Full flight: after launch, 54 frames → Y = 2. Frame 55 → shotActive = 0, Y stays 2. After 8 more frames → READY, and the next fire launches again.
- Hit with startOfFrame in the same cycle at Y = 200 → shotActive = 0 next cycle, Y stays 200, cooldown starts.
- fireKey held high for 200 frames → exactly one shotFired. A fire edge during FLYING or COOLDOWN → no second shot. Release and re-press after READY → launch.
- plrHit during FLIGHT (Y = 300) → shotActive = 0 next cycle, counter = 8. A fire press in the same frame is ignored.
